xadc_pair_sequencer: RTL and testbench

- Periodically reads two XADC auxiliary channels (left = VAUX3, right = VAUX2) over the XADC DRP port.
- Publishes both results as a coherent 16-bit pair with a one-cycle valid strobe.
- Sits between the XADC primitive and the analog-to-button game logic, replacing free-running direct sampling.
- Owns DRP sequencing, the sample rate, and timeout recovery.

---
 rtl/xadc_pair_sequencer_pkg.sv | 23 ++
 rtl/xadc_pair_sequencer_if.sv | 26 ++
 rtl/xadc_pair_sequencer_sample_tick_gen.sv | 33 +++
 rtl/xadc_pair_sequencer.sv | 136 +++++++++++++
 tb/tb_xadc_pair_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadc_pair_sequencer_pkg.sv
// Shared constants and state encoding for the XADC left/right pair sequencer.
package xadc_pkg;

    localparam logic [6:0] VAUX2_ADDR = 7'h12;
    localparam logic [6:0] VAUX3_ADDR = 7'h13;
    localparam int         DATA_SHIFT = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ_L,
        WAIT_L,
        REQ_R,
        WAIT_R,
        PUBLISH,
        ABORT
    } seq_state_e;

    // DRP status registers hold the 12-bit result left-justified in [15:4].
    function automatic logic [15:0] drp_to_code(input logic [15:0] drp_word);
        return drp_word >> DATA_SHIFT;
    endfunction

endpackage

// File: rtl/xadc_pair_sequencer_if.sv
// DRP read port between the pair sequencer (master) and the XADC primitive (slave).
interface xadc_pair_sequencer_if;

    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic        drp_drdy;
    logic [15:0] drp_do;

    modport master (
        output drp_den,
        output drp_dwe,
        output drp_daddr,
        input  drp_drdy,
        input  drp_do
    );

    modport slave (
        input  drp_den,
        input  drp_dwe,
        input  drp_daddr,
        output drp_drdy,
        output drp_do
    );

endinterface

// File: rtl/xadc_pair_sequencer_sample_tick_gen.sv
// Free-running 0..SAMPLE_DIV-1 counter; tick marks the last count of each period.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 100000
) (
    input  logic CLK100MHZ,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/xadc_pair_sequencer.sv
// Reads left then right XADC aux channels over DRP each sample tick and publishes them as a pair.
// state | meaning: IDLE wait tick, REQ_x den pulse, WAIT_x await drdy, PUBLISH pair valid, ABORT drdy timeout
module xadc_pair_sequencer
    import xadc_pkg::*;
#(
    parameter int         SAMPLE_DIV = 100000,
    parameter int         TIMEOUT    = 255,
    parameter logic [6:0] ADDR_L     = VAUX3_ADDR,
    parameter logic [6:0] ADDR_R     = VAUX2_ADDR
) (
    input  logic                        CLK100MHZ,
    input  logic                        rst,
    input  logic                        enable,
    xadc_pair_sequencer_if.master       drp,
    output logic [15:0]                 vauxp3,
    output logic [15:0]                 vauxp2,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [7:0]                  err_cnt
);

    localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

    seq_state_e  state_q,  state_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [15:0] left_q,   left_d;
    logic [15:0] vauxp3_q, vauxp3_d;
    logic [15:0] vauxp2_q, vauxp2_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        tick;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .tick      (tick)
    );

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        left_d        = left_q;
        vauxp3_d      = vauxp3_q;
        vauxp2_d      = vauxp2_q;
        err_cnt_d     = err_cnt_q;
        drp.drp_den   = 1'b0;
        drp.drp_daddr = 7'h00;
        sample_valid  = 1'b0;
        timeout_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    state_d = REQ_L;
                end
            end
            REQ_L: begin
                drp.drp_den   = 1'b1;
                drp.drp_daddr = ADDR_L;
                to_cnt_d      = TO_LOAD;
                state_d       = WAIT_L;
            end
            WAIT_L: begin
                drp.drp_daddr = ADDR_L;
                if (drp.drp_drdy) begin
                    left_d  = drp_to_code(drp.drp_do);
                    state_d = REQ_R;
                end else if (to_cnt_q == 8'd0) begin
                    state_d = ABORT;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            REQ_R: begin
                drp.drp_den   = 1'b1;
                drp.drp_daddr = ADDR_R;
                to_cnt_d      = TO_LOAD;
                state_d       = WAIT_R;
            end
            WAIT_R: begin
                drp.drp_daddr = ADDR_R;
                // Both outputs load together so the pair is already coherent while sample_valid is high.
                if (drp.drp_drdy) begin
                    vauxp3_d = left_q;
                    vauxp2_d = drp_to_code(drp.drp_do);
                    state_d  = PUBLISH;
                end else if (to_cnt_q == 8'd0) begin
                    state_d = ABORT;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            PUBLISH: begin
                sample_valid = 1'b1;
                state_d      = IDLE;
            end
            ABORT: begin
                timeout_err = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            left_q    <= '0;
            vauxp3_q  <= '0;
            vauxp2_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            left_q    <= left_d;
            vauxp3_q  <= vauxp3_d;
            vauxp2_q  <= vauxp2_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign drp.drp_dwe = 1'b0;
    assign busy        = (state_q != IDLE);
    assign vauxp3      = vauxp3_q;
    assign vauxp2      = vauxp2_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_xadc_pair_sequencer.sv
// Directed bench: two sequencers (short and long DRP timeout) driven by a behavioural XADC DRP responder.
module tb_xadc_pair_sequencer;
    import xadc_pkg::*;

    localparam int DIV  = 10;
    localparam int TO_A = 4;
    localparam int TO_B = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] en;

    xadc_pair_sequencer_if if_a ();
    xadc_pair_sequencer_if if_b ();

    logic [15:0] v3 [2];
    logic [15:0] v2 [2];
    logic [1:0]  valid;
    logic [1:0]  busy;
    logic [1:0]  terr;
    logic [7:0]  ecnt [2];

    xadc_pair_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT(TO_A)) dut_a (
        .CLK100MHZ (clk), .rst (rst), .enable (en[0]), .drp (if_a),
        .vauxp3 (v3[0]), .vauxp2 (v2[0]), .sample_valid (valid[0]),
        .busy (busy[0]), .timeout_err (terr[0]), .err_cnt (ecnt[0])
    );

    xadc_pair_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT(TO_B)) dut_b (
        .CLK100MHZ (clk), .rst (rst), .enable (en[1]), .drp (if_b),
        .vauxp3 (v3[1]), .vauxp2 (v2[1]), .sample_valid (valid[1]),
        .busy (busy[1]), .timeout_err (terr[1]), .err_cnt (ecnt[1])
    );

    logic [1:0]  den_w;
    logic [1:0]  dwe_w;
    logic [6:0]  addr_w [2];
    logic [1:0]  drdy_r = '0;
    logic [15:0] do_r [2] = '{16'h0, 16'h0};

    assign den_w[0]  = if_a.drp_den;
    assign den_w[1]  = if_b.drp_den;
    assign dwe_w[0]  = if_a.drp_dwe;
    assign dwe_w[1]  = if_b.drp_dwe;
    assign addr_w[0] = if_a.drp_daddr;
    assign addr_w[1] = if_b.drp_daddr;
    assign if_a.drp_drdy = drdy_r[0];
    assign if_a.drp_do   = do_r[0];
    assign if_b.drp_drdy = drdy_r[1];
    assign if_b.drp_do   = do_r[1];

    // responder configuration (written by the test tasks only)
    int          dly [2]  = '{2, 2};
    logic [1:0]  mute_l   = '0;
    logic [1:0]  mute_r   = '0;
    logic [1:0]  stale_en = '0;
    logic [15:0] dl [2]   = '{16'h0, 16'h0};
    logic [15:0] dr [2]   = '{16'h0, 16'h0};

    // responder state (written by the responder only)
    int          pend [2]    = '{0, 0};
    logic [15:0] pdata [2]   = '{16'h0, 16'h0};
    int          den_cnt [2] = '{0, 0};
    int          viol [2]    = '{0, 0};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // drdy rises dly cycles after the den cycle; a stale drdy can be forced while the DUT is idle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            drdy_r[i] = 1'b0;
            do_r[i]   = 16'hDEAD;
            if (pend[i] > 0) begin
                pend[i]--;
                if (pend[i] == 0) begin
                    drdy_r[i] = 1'b1;
                    do_r[i]   = pdata[i];
                end
            end else if (stale_en[i] && !busy[i]) begin
                drdy_r[i] = 1'b1;
                do_r[i]   = 16'hFFF0;
            end
            if (den_w[i]) begin
                den_cnt[i]++;
                if (pend[i] > 0) viol[i]++;
                if (addr_w[i] == VAUX3_ADDR && !mute_l[i]) begin
                    pend[i]  = dly[i];
                    pdata[i] = dl[i];
                end else if (addr_w[i] == VAUX2_ADDR && !mute_r[i]) begin
                    pend[i]  = dly[i];
                    pdata[i] = dr[i];
                end
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int rel_cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic observe(input int i, input int budget,
                           output int t1, output logic [6:0] a1,
                           output int t2, output logic [6:0] a2,
                           output int tv, output int te,
                           output logic [15:0] o3, output logic [15:0] o2,
                           output logic bz);
        int n;
        n = 0; t1 = -1; t2 = -1; tv = -1; te = -1;
        a1 = '0; a2 = '0; o3 = '0; o2 = '0; bz = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (den_w[i]) begin
                if (n == 0) begin t1 = cyc; a1 = addr_w[i]; end
                else if (n == 1) begin t2 = cyc; a2 = addr_w[i]; end
                n++;
            end
            if (valid[i]) begin tv = cyc; o3 = v3[i]; o2 = v2[i]; bz = busy[i]; break; end
            if (terr[i]) begin te = cyc; break; end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            total++; if (v3[i] !== 16'h0) begin bad++; $display("FAIL reset_vauxp3[%0d] got=%h exp=0000", i, v3[i]); end
            total++; if (v2[i] !== 16'h0) begin bad++; $display("FAIL reset_vauxp2[%0d] got=%h exp=0000", i, v2[i]); end
            total++; if ({valid[i], busy[i], terr[i], den_w[i], dwe_w[i]} !== 5'b0) begin
                bad++; $display("FAIL reset_flags[%0d] got=%b exp=00000", i, {valid[i], busy[i], terr[i], den_w[i], dwe_w[i]});
            end
            total++; if ({ecnt[i], addr_w[i]} !== 15'h0) begin
                bad++; $display("FAIL reset_errcnt_addr[%0d] got=%h/%h exp=0/0", i, ecnt[i], addr_w[i]);
            end
        end
    endtask

    int          t1, t2, tv, te, t1_prev;
    logic [6:0]  a1, a2;
    logic [15:0] o3, o2;
    logic        bz;

    task automatic test_basic();
        dly[0] = 2; dl[0] = 16'hABC0; dr[0] = 16'h1230;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        // tick counter starts at 0 on release, so the first tick is 9 cycles on and den follows it
        total++; if (t1 !== rel_cyc + 10) begin bad++; $display("FAIL basic_first_den got=%0d exp=%0d", t1, rel_cyc + 10); end
        total++; if (a1 !== 7'h13) begin bad++; $display("FAIL basic_addr_l got=%h exp=13", a1); end
        total++; if (a2 !== 7'h12) begin bad++; $display("FAIL basic_addr_r got=%h exp=12", a2); end
        total++; if (t2 - t1 !== 3) begin bad++; $display("FAIL basic_den_gap got=%0d exp=3", t2 - t1); end
        total++; if (tv - t1 !== 6) begin bad++; $display("FAIL basic_latency got=%0d exp=6", tv - t1); end
        total++; if (o3 !== 16'h0ABC) begin bad++; $display("FAIL basic_vauxp3 got=%h exp=0abc", o3); end
        total++; if (o2 !== 16'h0123) begin bad++; $display("FAIL basic_vauxp2 got=%h exp=0123", o2); end
        total++; if (bz !== 1'b1 || te !== -1) begin bad++; $display("FAIL basic_busy_err got=%b/%0d exp=1/-1", bz, te); end
        total++; if (dwe_w[0] !== 1'b0) begin bad++; $display("FAIL basic_dwe got=%b exp=0", dwe_w[0]); end
        @(negedge clk); #1;
        total++; if ({valid[0], busy[0]} !== 2'b00 || v3[0] !== 16'h0ABC) begin
            bad++; $display("FAIL basic_after got=%b/%h exp=00/0abc", {valid[0], busy[0]}, v3[0]);
        end
        t1_prev = t1;
        dly[0] = 1; dl[0] = 16'hFFFF; dr[0] = 16'h000F;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (t1 - t1_prev !== 10) begin bad++; $display("FAIL basic_period got=%0d exp=10", t1 - t1_prev); end
        total++; if (t2 - t1 !== 2 || tv - t1 !== 4) begin bad++; $display("FAIL basic_k1_timing got=%0d/%0d exp=2/4", t2 - t1, tv - t1); end
        total++; if (o3 !== 16'h0FFF || o2 !== 16'h0000) begin bad++; $display("FAIL basic_k1_data got=%h/%h exp=0fff/0000", o3, o2); end
    endtask

    // timeout_err lands in cycle den+TIMEOUT+1: TIMEOUT full WAIT cycles go by first
    task automatic test_timeout();
        dly[0] = 2; mute_r[0] = 1'b1;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (a2 !== 7'h12 || te - t2 !== TO_A + 1) begin bad++; $display("FAIL timeout_when got=%h/%0d exp=12/%0d", a2, te - t2, TO_A + 1); end
        total++; if (tv !== -1) begin bad++; $display("FAIL timeout_no_valid got=%0d exp=-1", tv); end
        @(negedge clk); #1;
        total++; if (ecnt[0] !== 8'd1) begin bad++; $display("FAIL timeout_errcnt got=%0d exp=1", ecnt[0]); end
        total++; if (v3[0] !== 16'h0FFF || v2[0] !== 16'h0000) begin bad++; $display("FAIL timeout_hold got=%h/%h exp=0fff/0000", v3[0], v2[0]); end
        t1_prev = t1;
        mute_r[0] = 1'b0; dl[0] = 16'h5550; dr[0] = 16'h7770;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (t1 - t1_prev !== 10) begin bad++; $display("FAIL timeout_restart got=%0d exp=10", t1 - t1_prev); end
        total++; if (o3 !== 16'h0555 || o2 !== 16'h0777) begin bad++; $display("FAIL timeout_recover got=%h/%h exp=0555/0777", o3, o2); end
    endtask

    task automatic test_expiry_drdy();
        dly[0] = TO_A; dl[0] = 16'h8005; dr[0] = 16'h3C3F;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (te !== -1 || tv - t1 !== 2 * TO_A + 2) begin bad++; $display("FAIL expiry_accept got=%0d/%0d exp=-1/%0d", te, tv - t1, 2 * TO_A + 2); end
        total++; if (o3 !== 16'h0800 || o2 !== 16'h03C3) begin bad++; $display("FAIL expiry_data got=%h/%h exp=0800/03c3", o3, o2); end
        @(negedge clk); #1;
        total++; if (ecnt[0] !== 8'd1) begin bad++; $display("FAIL expiry_errcnt got=%0d exp=1", ecnt[0]); end
        dly[0] = TO_A + 1;
        observe(0, 40, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (te - t1 !== TO_A + 1 || t2 !== -1) begin bad++; $display("FAIL expiry_late got=%0d/%0d exp=%0d/-1", te - t1, t2, TO_A + 1); end
        @(negedge clk); #1;
        total++; if (ecnt[0] !== 8'd2 || v3[0] !== 16'h0800) begin bad++; $display("FAIL expiry_late_state got=%0d/%h exp=2/0800", ecnt[0], v3[0]); end
    endtask

    task automatic test_enable_drop();
        bit found;
        bit seen_v;
        int dc;
        found = 0; seen_v = 0;
        dly[0] = 2; dl[0] = 16'h2460; dr[0] = 16'h1350;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (den_w[0]) begin found = 1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL endrop_den_wait got=none exp=den"); end
        @(negedge clk);
        en[0] = 1'b0;
        observe(0, 20, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (tv === -1 || a1 !== 7'h12) begin bad++; $display("FAIL endrop_complete got=%0d/%h exp=valid/12", tv, a1); end
        total++; if (o3 !== 16'h0246 || o2 !== 16'h0135) begin bad++; $display("FAIL endrop_data got=%h/%h exp=0246/0135", o3, o2); end
        dc = den_cnt[0];
        stale_en[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (valid[0]) seen_v = 1;
        end
        stale_en[0] = 1'b0;
        total++; if (den_cnt[0] - dc !== 0) begin bad++; $display("FAIL endrop_no_den got=%0d exp=0", den_cnt[0] - dc); end
        total++; if (seen_v !== 1'b0 || v3[0] !== 16'h0246 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL endrop_stale got=%b/%h/%b exp=0/0246/0", seen_v, v3[0], busy[0]);
        end
        total++; if (viol[0] !== 0) begin bad++; $display("FAIL endrop_outstanding got=%0d exp=0", viol[0]); end
    endtask

    task automatic test_long_delay();
        int dc;
        dly[1] = 20; dl[1] = 16'h0010; dr[1] = 16'hFFF0;
        en[1] = 1'b1;
        observe(1, 60, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (t2 - t1 !== 21 || tv - t1 !== 42) begin bad++; $display("FAIL long_timing got=%0d/%0d exp=21/42", t2 - t1, tv - t1); end
        total++; if (o3 !== 16'h0001 || o2 !== 16'h0FFF) begin bad++; $display("FAIL long_data got=%h/%h exp=0001/0fff", o3, o2); end
        t1_prev = t1;
        dc = den_cnt[1];
        observe(1, 80, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (t1 - t1_prev !== 50) begin bad++; $display("FAIL long_drop_ticks got=%0d exp=50", t1 - t1_prev); end
        total++; if (den_cnt[1] - dc !== 2 || a1 !== 7'h13 || a2 !== 7'h12) begin
            bad++; $display("FAIL long_den_count got=%0d/%h/%h exp=2/13/12", den_cnt[1] - dc, a1, a2);
        end
        total++; if (viol[1] !== 0 || te !== -1) begin bad++; $display("FAIL long_outstanding got=%0d/%0d exp=0/-1", viol[1], te); end
        en[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        bit seen_v;
        found = 0; seen_v = 0;
        dly[0] = 3; dl[0] = 16'h1000; dr[0] = 16'h2000;
        en[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (den_w[0] && addr_w[0] == VAUX2_ADDR) begin found = 1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_den_wait got=none exp=den"); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({v3[0], v2[0]} !== 32'h0 || ecnt[0] !== 8'd0) begin
            bad++; $display("FAIL rstmid_regs got=%h/%h/%0d exp=0/0/0", v3[0], v2[0], ecnt[0]);
        end
        total++; if ({busy[0], valid[0], terr[0], den_w[0]} !== 4'b0 || addr_w[0] !== 7'h0) begin
            bad++; $display("FAIL rstmid_flags got=%b/%h exp=0000/00", {busy[0], valid[0], terr[0], den_w[0]}, addr_w[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (valid[0] || busy[0]) seen_v = 1;
        end
        total++; if (seen_v !== 1'b0 || v3[0] !== 16'h0 || v2[0] !== 16'h0) begin
            bad++; $display("FAIL rstmid_late_drdy got=%b/%h/%h exp=0/0000/0000", seen_v, v3[0], v2[0]);
        end
        observe(0, 30, t1, a1, t2, a2, tv, te, o3, o2, bz);
        total++; if (t1 !== rel_cyc + 10 || tv - t1 !== 8) begin bad++; $display("FAIL rstmid_next_timing got=%0d/%0d exp=%0d/8", t1, tv - t1, rel_cyc + 10); end
        total++; if (o3 !== 16'h0100 || o2 !== 16'h0200) begin bad++; $display("FAIL rstmid_next_data got=%h/%h exp=0100/0200", o3, o2); end
        total++; if (viol[0] !== 0) begin bad++; $display("FAIL rstmid_outstanding got=%0d exp=0", viol[0]); end
    endtask

    task automatic test_saturation();
        int n;
        logic [7:0] e255, e256;
        n = 0; e255 = '0; e256 = '0;
        mute_l[0] = 1'b1;
        for (int c = 0; c < 3100; c++) begin
            @(negedge clk); #1;
            if (terr[0]) begin
                n++;
                if (n == 255) e255 = ecnt[0];
                if (n == 256) e256 = ecnt[0];
                if (n == 300) break;
            end
        end
        @(negedge clk); #1;
        total++; if (n !== 300) begin bad++; $display("FAIL sat_pulses got=%0d exp=300", n); end
        total++; if (e255 !== 8'd254 || e256 !== 8'd255) begin bad++; $display("FAIL sat_edge got=%0d/%0d exp=254/255", e255, e256); end
        total++; if (ecnt[0] !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", ecnt[0]); end
        total++; if (v3[0] !== 16'h0100 || v2[0] !== 16'h0200) begin bad++; $display("FAIL sat_hold got=%h/%h exp=0100/0200", v3[0], v2[0]); end
        mute_l[0] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        en[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        test_basic();
        test_timeout();
        test_expiry_drdy();
        test_enable_drop();
        test_long_delay();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
